// File: rtl/bit_deserializer.sv
// bit_deserializer: assembles a serial bit stream into WIDTH-bit words behind a one-word valid/ready holding register
// Optional feature macro: DESER_PARITY_EN (adds out_parity, even parity of out_word)
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   in_bit, in_valid      serial input bit and its qualifier
//   in_ready              combinational; a bit is accepted when in_valid & in_ready
//   flush                 drops the partially assembled word
//   out_word, out_valid   registered output word and its qualifier
//   out_ready             consumer takes the word when out_valid & out_ready
//   bit_count             bits currently held in the partial word
//   out_parity            ^out_word, registered with out_word (DESER_PARITY_EN only)
module bit_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 0,
    localparam int CW       = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_bit,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [WIDTH-1:0] out_word,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef DESER_PARITY_EN
    output logic             out_parity,
`endif
    output logic [CW-1:0]    bit_count
);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t           state, next_state;
    logic [WIDTH-1:0] shift_reg, shifted;
    logic [CW-1:0]    next_count;
    logic             last, accept, load, next_valid;
    // The shifted value doubles as the finished word on the final bit, so the
    // WIDTH-th bit reaches out_word in the same cycle it is accepted.
    always_comb begin
        last       = bit_count == CW'(WIDTH - 1);
        in_ready   = ~flush & ~(last & out_valid & ~out_ready);
        accept     = in_valid & in_ready;
        load       = accept & last;
        shifted    = MSB_FIRST ? {shift_reg[WIDTH-2:0], in_bit} : {in_bit, shift_reg[WIDTH-1:1]};
        next_valid = load | (out_valid & ~out_ready);
        next_state = state;
        next_count = bit_count;
        if (flush) begin
            next_state = IDLE;
            next_count = '0;
        end else if (accept) begin
            next_state = last ? IDLE : SHIFT;
            next_count = last ? '0 : bit_count + 1'b1;
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            bit_count <= '0;
            shift_reg <= '0;
            out_word  <= '0;
            out_valid <= 1'b0;
`ifdef DESER_PARITY_EN
            out_parity <= 1'b0;
`endif
        end else begin
            state     <= next_state;
            bit_count <= next_count;
            out_valid <= next_valid;
            if (accept) shift_reg <= shifted;
            if (load) begin
                out_word <= shifted;
`ifdef DESER_PARITY_EN
                out_parity <= ^shifted;
`endif
            end
        end
    end
endmodule

// File: tb/tb_bit_deserializer.sv
// tb_bit_deserializer: directed checks of LSB-first and MSB-first deserializer instances
module tb_bit_deserializer;
    logic       clock = 1'b0;
    logic       reset, in_bit, in_valid, flush, out_ready;
    logic       in_ready_l, out_valid_l, in_ready_m, out_valid_m;
    logic [7:0] out_word_l, out_word_m;
    logic [2:0] bit_count_l, bit_count_m;
`ifdef DESER_PARITY_EN
    logic       out_parity_l, out_parity_m;
`endif
    int checks = 0;
    int errors = 0;
    logic [7:0] words [3] = '{8'hA5, 8'h07, 8'hE0};
    logic [7:0] revs  [3] = '{8'hA5, 8'hE0, 8'h07};
    logic       pars  [3] = '{1'b0, 1'b1, 1'b1};

    bit_deserializer #(.WIDTH(8), .MSB_FIRST(0)) dut_l (
        .clock(clock), .reset(reset), .in_bit(in_bit), .in_valid(in_valid),
        .in_ready(in_ready_l), .flush(flush), .out_word(out_word_l),
        .out_valid(out_valid_l), .out_ready(out_ready),
`ifdef DESER_PARITY_EN
        .out_parity(out_parity_l),
`endif
        .bit_count(bit_count_l)
    );

    bit_deserializer #(.WIDTH(8), .MSB_FIRST(1)) dut_m (
        .clock(clock), .reset(reset), .in_bit(in_bit), .in_valid(in_valid),
        .in_ready(in_ready_m), .flush(flush), .out_word(out_word_m),
        .out_valid(out_valid_m), .out_ready(out_ready),
`ifdef DESER_PARITY_EN
        .out_parity(out_parity_m),
`endif
        .bit_count(bit_count_m)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bits(input logic [7:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            in_bit   = w[i];
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_bit = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        tick(); tick();
        chk("reset out_word", 32'(out_word_l), 32'h00);
        chk("reset out_valid", 32'(out_valid_l), 32'h0);
        chk("reset bit_count", 32'(bit_count_l), 32'h0);
        chk("reset in_ready", 32'(in_ready_l), 32'h1);
`ifdef DESER_PARITY_EN
        chk("reset out_parity", 32'(out_parity_l), 32'h0);
`endif
        reset = 1'b0;
        out_ready = 1'b1;
        // 1/2: 1,0,1,1,0,0,0,1 -> 8D LSB-first, B1 MSB-first
        send_bits(8'h8D, 7);
        chk("t1 valid before last bit", 32'(out_valid_l), 32'h0);
        chk("t1 bit_count 7", 32'(bit_count_l), 32'h7);
        in_bit = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t1 out_valid", 32'(out_valid_l), 32'h1);
        chk("t1 out_word", 32'(out_word_l), 32'h8D);
        chk("t2 out_word msb", 32'(out_word_m), 32'hB1);
        chk("t1 bit_count 0", 32'(bit_count_l), 32'h0);
`ifdef DESER_PARITY_EN
        chk("t1 parity", 32'(out_parity_l), 32'h0);
        chk("t2 parity msb", 32'(out_parity_m), 32'h0);
`endif
        tick();
        chk("t1 valid one cycle", 32'(out_valid_l), 32'h0);
        chk("t1 word kept", 32'(out_word_l), 32'h8D);
        // 3: held word, final-bit stall, then simultaneous drain and load
        out_ready = 1'b0;
        send_bits(8'h8D, 8);
        chk("t3 first valid", 32'(out_valid_l), 32'h1);
        send_bits(8'h3C, 7);
        chk("t3 word held", 32'(out_word_l), 32'h8D);
        chk("t3 valid held", 32'(out_valid_l), 32'h1);
        in_bit = 1'b0; in_valid = 1'b1;
        #1;
        chk("t3 stall in_ready", 32'(in_ready_l), 32'h0);
        tick();
        chk("t3 stall bit_count", 32'(bit_count_l), 32'h7);
        chk("t3 stall word", 32'(out_word_l), 32'h8D);
        out_ready = 1'b1;
        #1;
        chk("t3 release in_ready", 32'(in_ready_l), 32'h1);
        tick();
        in_valid = 1'b0;
        chk("t3 second valid", 32'(out_valid_l), 32'h1);
        chk("t3 second word", 32'(out_word_l), 32'h3C);
        chk("t3 second word msb", 32'(out_word_m), 32'h3C);
        tick();
        chk("t3 drained", 32'(out_valid_l), 32'h0);
        // 4: 24 continuous bits, one word every 8 cycles, never stalled
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < 8; i++) begin
                in_bit = words[w][i]; in_valid = 1'b1;
                #1;
                chk("t4 in_ready", 32'(in_ready_l), 32'h1);
                tick();
                chk("t4 out_valid", 32'(out_valid_l), (i == 7) ? 32'h1 : 32'h0);
            end
            chk("t4 out_word", 32'(out_word_l), 32'(words[w]));
            chk("t4 out_word msb", 32'(out_word_m), 32'(revs[w]));
`ifdef DESER_PARITY_EN
            chk("t4 parity", 32'(out_parity_l), 32'(pars[w]));
            chk("t4 parity msb", 32'(out_parity_m), 32'(pars[w]));
`endif
        end
        in_valid = 1'b0;
        // 5: reset mid-word leaves nothing behind
        send_bits(8'hFF, 3);
        reset = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t5 reset out_word", 32'(out_word_l), 32'h00);
        chk("t5 reset out_valid", 32'(out_valid_l), 32'h0);
        chk("t5 reset bit_count", 32'(bit_count_l), 32'h0);
`ifdef DESER_PARITY_EN
        chk("t5 reset parity", 32'(out_parity_l), 32'h0);
`endif
        reset = 1'b0;
        send_bits(8'h5A, 7);
        chk("t5 no early word", 32'(out_valid_l), 32'h0);
        in_bit = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t5 out_valid", 32'(out_valid_l), 32'h1);
        chk("t5 out_word", 32'(out_word_l), 32'h5A);
        chk("t5 out_word msb", 32'(out_word_m), 32'h5A);
        // 6: flush drops the partial word and the same-cycle bit
        send_bits(8'hFF, 5);
        chk("t6 bit_count 5", 32'(bit_count_l), 32'h5);
        flush = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
        #1;
        chk("t6 flush in_ready", 32'(in_ready_l), 32'h0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("t6 flushed count", 32'(bit_count_l), 32'h0);
        send_bits(8'h8D, 8);
        chk("t6 out_valid", 32'(out_valid_l), 32'h1);
        chk("t6 out_word", 32'(out_word_l), 32'h8D);
`ifdef DESER_PARITY_EN
        chk("t6 parity 8D", 32'(out_parity_l), 32'h0);
`endif
        send_bits(8'h07, 8);
        chk("t6 out_word 07", 32'(out_word_l), 32'h07);
        chk("t6 out_word msb E0", 32'(out_word_m), 32'hE0);
`ifdef DESER_PARITY_EN
        chk("t6 parity 07", 32'(out_parity_l), 32'h1);
        chk("t6 parity msb E0", 32'(out_parity_m), 32'h1);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
